dmem_store_buffer: RTL and testbench

//  Store buffer between the pipelined MIPS core's MEM-stage data port and a data RAM with multi-cycle write latency.

---
 rtl/dmem_store_buffer.sv | 100 ++++++++++
 tb/tb_dmem_store_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Store buffer between the core's MEM-stage data port and a multi-cycle-write data RAM.
// Stores queue in a circular FIFO, drain through a req/ack handshake, and forward to loads (youngest wins).
module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack
);

    localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        WRITE
    } drainState_t;

    logic [29:0]     entryAddr [DEPTH];
    logic [31:0]     entryData [DEPTH];
    logic [PtrW-1:0] head;
    logic [PtrW-1:0] tail;
    logic [PtrW-1:0] fwdIdx;
    logic [PtrW:0]   count;
    logic [PtrW:0]   countNext;
    drainState_t     state;
    drainState_t     stateNext;
    logic            push;
    logic            pop;
    logic            drop;

    // A pop in the same cycle frees a slot, so a full buffer can still accept a store.
    assign pop       = (state == WRITE) && mem_ack;
    assign full      = (count == (PtrW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = memwrite && (!full || pop);
    assign drop      = memwrite && full && !pop;
    assign countNext = count + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};

    assign mem_we    = (state == WRITE);
    assign mem_waddr = {entryAddr[head], 2'b00};
    assign mem_wdata = entryData[head];
    assign mem_raddr = {addr[31:2], 2'b00};

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (count != '0) stateNext = WRITE;
            WRITE:   if (pop && (countNext == '0)) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (push) tail <= tail + PtrW'(1);
            if (pop)  head <= head + PtrW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entryAddr[tail] <= addr[31:2];
            entryData[tail] <= wdata;
        end
    end

    // Walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        rdata  = mem_rdata;
        fwdIdx = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx = head + PtrW'(i);
            if (((PtrW+1)'(i) < count) && (entryAddr[fwdIdx] == addr[31:2])) begin
                rdata = entryData[fwdIdx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: queue-based reference model, RAM model, directed and random phases.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .wdata(wdata),
        .rdata(rdata), .full(full), .empty(empty), .overflow(overflow),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
    );

    // RAM model: combinational read, write on an acknowledged request
    logic [31:0] ram [256];
    assign mem_rdata = ram[mem_raddr[9:2]];
    always @(posedge clk) if (mem_we && mem_ack) ram[mem_waddr[9:2]] <= mem_wdata;

    typedef struct packed {
        logic [29:0] w;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t expW[$];
    ent_t e;
    bit   mWe = 1'b0;
    bit   mOvf = 1'b0;
    bit   popNow;
    bit   hadEntries;
    int   checks = 0;
    int   errors = 0;
    bit   checkOn = 1'b0;
    int   ackMode = 0;
    int   ackDelay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expRdata();
        logic [31:0] r;
        r = ram[addr[9:2]];
        for (int i = 0; i < mq.size(); i++) if (mq[i].w == addr[31:2]) r = mq[i].d;
        return r;
    endfunction

    // Reference model: buffer as a queue of pending stores, request raised a cycle after it holds data
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            expW.delete();
            mWe  = 1'b0;
            mOvf = 1'b0;
        end else begin
            popNow     = mWe && mem_ack;
            hadEntries = (mq.size() > 0);
            if (popNow) void'(mq.pop_front());
            if (memwrite) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back('{w: addr[31:2], d: wdata});
                    expW.push_back('{w: addr[31:2], d: wdata});
                end else begin
                    mOvf = 1'b1;
                end
            end
            if (!mWe) mWe = hadEntries;
            else if (popNow) mWe = (mq.size() > 0);
        end
    end

    // Monitor: status, forwarding and every RAM write checked mid-cycle
    always @(negedge clk) begin
        if (!reset && checkOn) begin
            chk("empty", empty, 32'(mq.size() == 0));
            chk("full", full, 32'(mq.size() == DEPTH));
            chk("overflow", overflow, 32'(mOvf));
            chk("mem_we", mem_we, 32'(mWe));
            chk("rdata", rdata, expRdata());
            chk("mem_raddr", mem_raddr, {addr[31:2], 2'b00});
            if (mWe && mq.size() > 0) begin
                chk("mem_waddr", mem_waddr, {mq[0].w, 2'b00});
                chk("mem_wdata", mem_wdata, mq[0].d);
            end
            if (mem_we && mem_ack) begin
                checks++;
                if (expW.size() == 0) begin
                    errors++;
                    $display("FAIL ram_write: got write to %h with no pending store expected", mem_waddr);
                end else begin
                    e = expW.pop_front();
                    if (mem_waddr !== {e.w, 2'b00} || mem_wdata !== e.d) begin
                        errors++;
                        $display("FAIL ram_write: got %h=%h expected %h=%h",
                                 mem_waddr, mem_wdata, {e.w, 2'b00}, e.d);
                    end
                end
            end
        end
    end

    // RAM acknowledge: 0 = never, 1 = always, otherwise random 0-3 cycle delay per write
    always begin
        @(posedge clk);
        #1;
        case (ackMode)
            0: mem_ack = 1'b0;
            1: mem_ack = 1'b1;
            default: begin
                if (mem_we) begin
                    if (ackDelay == 0) begin
                        mem_ack  = 1'b1;
                        ackDelay = $urandom_range(0, 3);
                    end else begin
                        mem_ack = 1'b0;
                        ackDelay--;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
            end
        endcase
    end

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        memwrite = we;
        addr     = a;
        wdata    = d;
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 | i;
        mem_ack  = 1'b0;
        reset    = 1'b1;
        memwrite = 1'b1;
        addr     = 32'h80;
        wdata    = 32'h1234_5678;

        // reset held two cycles with a store strobe active
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        memwrite = 1'b0;
        @(negedge clk);
        chk("rst_empty", empty, 32'd1);
        chk("rst_full", full, 32'd0);
        chk("rst_mem_we", mem_we, 32'd0);
        chk("rst_overflow", overflow, 32'd0);
        checkOn = 1'b1;

        // single store drained with ack tied high
        ackMode = 1;
        drive(1'b1, 32'h100, 32'hDEAD_BEEF);
        drive(1'b0, 32'h100, 32'h0);
        chk("single_we_idle", mem_we, 32'd0);
        chk("single_not_empty", empty, 32'd0);
        drive(1'b0, 32'h100, 32'h0);
        chk("single_we", mem_we, 32'd1);
        chk("single_waddr", mem_waddr, 32'h100);
        chk("single_wdata", mem_wdata, 32'hDEAD_BEEF);
        drive(1'b0, 32'h0, 32'h0);
        chk("single_empty", empty, 32'd1);

        // forwarding: youngest of two stores to one word
        ackMode = 0;
        drive(1'b1, 32'h40, 32'h11);
        drive(1'b1, 32'h40, 32'h22);
        drive(1'b0, 32'h40, 32'h0);
        chk("fwd_youngest", rdata, 32'h22);
        drive(1'b0, 32'h44, 32'h0);
        chk("fwd_miss", rdata, 32'hA500_0011);
        ackMode = 1;
        repeat (6) drive(1'b0, 32'h0, 32'h0);
        chk("fwd_ram_final", ram[16], 32'h22);

        // fill and overflow
        ackMode = 0;
        doReset();
        for (int i = 1; i <= 5; i++) drive(1'b1, 32'h200 + 32'(4 * (i - 1)), 32'(i));
        chk("fill_full", full, 32'd1);
        chk("fill_no_ovf_yet", overflow, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        chk("fill_overflow", overflow, 32'd1);
        ackMode = 1;
        repeat (8) drive(1'b0, 32'h0, 32'h0);
        chk("fill_drained", empty, 32'd1);
        chk("fill_ovf_sticky", overflow, 32'd1);
        chk("fill_ram_4th", ram[8'h83], 32'd4);
        chk("fill_5th_dropped", ram[8'h84], 32'hA500_0084);

        // push and pop together while full
        ackMode = 0;
        doReset();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + 32'(4 * i), 32'h50 + 32'(i));
        drive(1'b0, 32'h0, 32'h0);
        chk("pp_full", full, 32'd1);
        ackMode = 1;
        drive(1'b1, 32'h310, 32'h55);
        drive(1'b0, 32'h310, 32'h0);
        chk("pp_still_full", full, 32'd1);
        chk("pp_no_overflow", overflow, 32'd0);
        chk("pp_forward", rdata, 32'h55);
        repeat (8) drive(1'b0, 32'h0, 32'h0);
        chk("pp_drained", empty, 32'd1);

        // reset while entries are pending
        ackMode = 0;
        drive(1'b1, 32'h180, 32'h77);
        drive(1'b1, 32'h184, 32'h88);
        drive(1'b0, 32'h0, 32'h0);
        doReset();
        chk("midrst_we", mem_we, 32'd0);
        chk("midrst_empty", empty, 32'd1);

        // random stores and loads with random ack delays, pointers wrap many times
        ackMode = 2;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 6)
                drive(1'b1, 32'h380 + 32'(4 * $urandom_range(0, 7)), $urandom);
            else
                drive(1'b0, 32'h380 + 32'(4 * $urandom_range(0, 7)), 32'h0);
        end
        for (int k = 0; k < 100 && !(mq.size() == 0 && empty); k++) drive(1'b0, 32'h0, 32'h0);
        chk("rand_empty", empty, 32'd1);
        chk("rand_scoreboard_left", 32'(expW.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
